// File: rtl/pll_mgmt_responder.sv
// Avalon-MM slave holding pending/active PLL divider registers; an apply write
// stalls the bus, commits pending to active, then models relock on `locked`.
module pll_mgmt_responder #(
    parameter logic [31:0] M_INIT       = 32'h00808,
    parameter logic [31:0] N_INIT       = 32'h10000,
    parameter logic [31:0] K_INIT       = 32'hB33332DD,
    parameter logic [31:0] C_INIT       = 32'h20302,
    parameter int          APPLY_CYCLES = 16,
    parameter int          LOCK_CYCLES  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  mgmt_address,
    input  logic        mgmt_write,
    input  logic [31:0] mgmt_writedata,
    input  logic        mgmt_read,
    output logic [31:0] mgmt_readdata,
    output logic        mgmt_readdatavalid,
    output logic        mgmt_waitrequest,
    input  logic        pll_rst,
    output logic        locked,
    output logic [31:0] m_cfg,
    output logic [31:0] n_cfg,
    output logic [31:0] k_cfg,
    output logic [31:0] c0_cfg,
    output logic [3:0]  bw_cfg,
    output logic [3:0]  cp_cfg,
    output logic        cfg_applied
);

    generate
        if (APPLY_CYCLES < 1 || APPLY_CYCLES > 65535 || LOCK_CYCLES < 1 || LOCK_CYCLES > 65535 ||
            M_INIT == 32'd0 || N_INIT == 32'd0 || K_INIT == 32'd0 || C_INIT == 32'd0) begin : g_bad_param
            $error("pll_mgmt_responder: zero or out-of-range parameter");
        end
    endgenerate

    localparam logic [15:0] APPLY_LOAD = 16'(APPLY_CYCLES);
    localparam logic [15:0] LOCK_LOAD  = 16'(LOCK_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_APPLY, ST_RELOCK} state_t;

    state_t      state, state_nx;
    logic [15:0] count, count_nx;
    logic        apply_done;
    logic        wr_acc, rd_acc, apply_req, busy;
    logic [31:0] rd_mux;

    logic [31:0] mode, pend_m, pend_n, pend_k, pend_c0;
    logic [3:0]  pend_bw, pend_cp;

    assign mgmt_waitrequest = (state == ST_APPLY);
    assign busy             = (state != ST_IDLE);
    assign locked           = (state == ST_IDLE) && !pll_rst;

    // A simultaneous read is dropped in favour of the write.
    assign wr_acc    = mgmt_write && !mgmt_waitrequest;
    assign rd_acc    = mgmt_read && !mgmt_write && !mgmt_waitrequest;
    assign apply_req = wr_acc && (mgmt_address == 6'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RELOCK;
            count <= LOCK_LOAD;
        end else begin
            state <= state_nx;
            count <= count_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        count_nx   = count;
        apply_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (apply_req) begin
                    state_nx = ST_APPLY;
                    count_nx = APPLY_LOAD;
                end else if (pll_rst) begin
                    state_nx = ST_RELOCK;
                    count_nx = LOCK_LOAD;
                end
            end
            ST_APPLY: begin
                if (count == 16'd1) begin
                    apply_done = 1'b1;
                    state_nx   = ST_RELOCK;
                    count_nx   = LOCK_LOAD;
                end else begin
                    count_nx = count - 16'd1;
                end
            end
            ST_RELOCK: begin
                if (apply_req) begin
                    state_nx = ST_APPLY;
                    count_nx = APPLY_LOAD;
                end else if (pll_rst) begin
                    count_nx = LOCK_LOAD;
                end else if (count == 16'd1) begin
                    state_nx = ST_IDLE;
                end else begin
                    count_nx = count - 16'd1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                count_nx = 16'd0;
            end
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (mgmt_address)
            6'd0:    rd_mux = mode;
            6'd1:    rd_mux = {30'd0, locked, busy};
            6'd3:    rd_mux = pend_n;
            6'd4:    rd_mux = pend_m;
            6'd5:    rd_mux = pend_c0;
            6'd7:    rd_mux = pend_k;
            6'd8:    rd_mux = {28'd0, pend_bw};
            6'd9:    rd_mux = {28'd0, pend_cp};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode               <= 32'd0;
            pend_m             <= M_INIT;
            pend_n             <= N_INIT;
            pend_k             <= K_INIT;
            pend_c0            <= C_INIT;
            pend_bw            <= 4'd7;
            pend_cp            <= 4'd1;
            m_cfg              <= M_INIT;
            n_cfg              <= N_INIT;
            k_cfg              <= K_INIT;
            c0_cfg             <= C_INIT;
            bw_cfg             <= 4'd7;
            cp_cfg             <= 4'd1;
            cfg_applied        <= 1'b0;
            mgmt_readdata      <= 32'd0;
            mgmt_readdatavalid <= 1'b0;
        end else begin
            cfg_applied        <= apply_done;
            mgmt_readdatavalid <= rd_acc;
            if (rd_acc) begin
                mgmt_readdata <= rd_mux;
            end
            if (wr_acc) begin
                case (mgmt_address)
                    6'd0:    mode    <= mgmt_writedata;
                    6'd3:    pend_n  <= mgmt_writedata;
                    6'd4:    pend_m  <= mgmt_writedata;
                    6'd5:    pend_c0 <= mgmt_writedata;
                    6'd7:    pend_k  <= mgmt_writedata;
                    6'd8:    pend_bw <= mgmt_writedata[3:0];
                    6'd9:    pend_cp <= mgmt_writedata[3:0];
                    default: ;
                endcase
            end
            // Writes are stalled during APPLY, so the commit never races a write.
            if (apply_done) begin
                m_cfg  <= pend_m;
                n_cfg  <= pend_n;
                k_cfg  <= pend_k;
                c0_cfg <= pend_c0;
                bw_cfg <= pend_bw;
                cp_cfg <= pend_cp;
            end
        end
    end

endmodule

// File: tb/tb_pll_mgmt_responder.sv
// Scenario bench for pll_mgmt_responder: reads are scored through a queue of
// expected data popped when readdatavalid appears.
module tb_pll_mgmt_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  mgmt_address = '0;
    logic        mgmt_write = 1'b0;
    logic [31:0] mgmt_writedata = '0;
    logic        mgmt_read = 1'b0;
    logic [31:0] mgmt_readdata;
    logic        mgmt_readdatavalid;
    logic        mgmt_waitrequest;
    logic        pll_rst = 1'b0;
    logic        locked;
    logic [31:0] m_cfg, n_cfg, k_cfg, c0_cfg;
    logic [3:0]  bw_cfg, cp_cfg;
    logic        cfg_applied;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_q[$];

    pll_mgmt_responder dut (
        .clk(clk), .rst_n(rst_n),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
        .mgmt_read(mgmt_read), .mgmt_readdata(mgmt_readdata),
        .mgmt_readdatavalid(mgmt_readdatavalid), .mgmt_waitrequest(mgmt_waitrequest),
        .pll_rst(pll_rst), .locked(locked),
        .m_cfg(m_cfg), .n_cfg(n_cfg), .k_cfg(k_cfg), .c0_cfg(c0_cfg),
        .bw_cfg(bw_cfg), .cp_cfg(cp_cfg), .cfg_applied(cfg_applied)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && mgmt_readdatavalid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_readdatavalid got data=%h required none", mgmt_readdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (mgmt_readdata !== e) begin
                    bad++;
                    $display("FAIL readdata got=%h required=%h", mgmt_readdata, e);
                end
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (mgmt_waitrequest && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL %s waitrequest_timeout got=stuck required=release", name);
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        mgmt_write = 1'b1;
        mgmt_address = a;
        mgmt_writedata = d;
        wait_ready("write");
        @(posedge clk);
        #1 mgmt_write = 1'b0;
    endtask

    task automatic bus_read(input logic [5:0] a, input logic [31:0] e);
        @(negedge clk);
        mgmt_read = 1'b1;
        mgmt_address = a;
        wait_ready("read");
        exp_q.push_back(e);
        @(posedge clk);
        #1 mgmt_read = 1'b0;
        total++;
        if (mgmt_readdatavalid !== 1'b1) begin
            bad++;
            $display("FAIL read_latency addr=%0d readdatavalid got=%b required=1", a, mgmt_readdatavalid);
        end
    endtask

    task automatic drain;
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_lock_after(input int cycles, input string name);
        int early = 0;
        for (int i = 0; i < cycles - 1; i++) begin
            @(negedge clk);
            if (locked !== 1'b0) early++;
        end
        total++;
        if (early != 0) begin
            bad++;
            $display("FAIL %s_early_lock got=%0d_cycles_high required=0", name, early);
        end
        @(negedge clk);
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL %s_lock got=%b required=1", name, locked);
        end
    endtask

    task automatic wait_locked;
        int n = 0;
        while (!locked && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!locked) begin
            bad++;
            $display("FAIL lock_timeout got=0 required=1");
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total += 6;
        if (mgmt_waitrequest !== 1'b0) begin bad++; $display("FAIL rst_waitrequest got=%b required=0", mgmt_waitrequest); end
        if (mgmt_readdatavalid !== 1'b0) begin bad++; $display("FAIL rst_rdv got=%b required=0", mgmt_readdatavalid); end
        if (mgmt_readdata !== 32'd0) begin bad++; $display("FAIL rst_readdata got=%h required=0", mgmt_readdata); end
        if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked got=%b required=0", locked); end
        if (cfg_applied !== 1'b0) begin bad++; $display("FAIL rst_cfg_applied got=%b required=0", cfg_applied); end
        if (bw_cfg !== 4'd7 || cp_cfg !== 4'd1) begin bad++; $display("FAIL rst_bw_cp got=%h/%h required=7/1", bw_cfg, cp_cfg); end
        rst_n = 1'b1;
        check_lock_after(64, "reset");
        total += 2;
        if (m_cfg !== 32'h00808) begin bad++; $display("FAIL rst_m_cfg got=%h required=00808", m_cfg); end
        if (k_cfg !== 32'hB33332DD) begin bad++; $display("FAIL rst_k_cfg got=%h required=b33332dd", k_cfg); end
    endtask

    task automatic test_pending_write;
        bus_write(6'd4, 32'h00707);
        bus_read(6'd4, 32'h00707);
        @(posedge clk);
        #1;
        total++;
        if (mgmt_readdatavalid !== 1'b0) begin bad++; $display("FAIL rdv_one_cycle got=%b required=0", mgmt_readdatavalid); end
        drain();
        total++;
        if (m_cfg !== 32'h00808) begin bad++; $display("FAIL m_before_apply got=%h required=00808", m_cfg); end
        bus_read(6'd1, 32'd2);
        drain();
    endtask

    task automatic test_full_sequence;
        int n = 0;
        int pulses = 0;
        bus_write(6'd0, 32'd1);
        bus_write(6'd4, 32'h00808);
        bus_write(6'd7, 32'd1);
        bus_write(6'd3, 32'h10000);
        bus_write(6'd5, 32'h20302);
        bus_write(6'd9, 32'd2);
        bus_write(6'd8, 32'd6);
        total++;
        if (k_cfg !== 32'hB33332DD) begin bad++; $display("FAIL k_before_apply got=%h required=b33332dd", k_cfg); end
        bus_write(6'd2, 32'd0);
        @(negedge clk);
        while (mgmt_waitrequest && n < 100) begin
            if (cfg_applied) pulses++;
            n++;
            @(negedge clk);
        end
        total += 4;
        if (n != 16) begin bad++; $display("FAIL apply_stall_cycles got=%0d required=16", n); end
        if (cfg_applied !== 1'b1) begin bad++; $display("FAIL cfg_applied_pulse got=%b required=1", cfg_applied); end
        if (m_cfg !== 32'h00808 || k_cfg !== 32'd1 || c0_cfg !== 32'h20302 || n_cfg !== 32'h10000) begin
            bad++;
            $display("FAIL applied_dividers got m=%h k=%h c0=%h n=%h required 00808/1/20302/10000", m_cfg, k_cfg, c0_cfg, n_cfg);
        end
        if (bw_cfg !== 4'd6 || cp_cfg !== 4'd2) begin bad++; $display("FAIL applied_bw_cp got=%h/%h required=6/2", bw_cfg, cp_cfg); end
        @(negedge clk);
        total++;
        if (cfg_applied !== 1'b0 || pulses != 0) begin bad++; $display("FAIL cfg_applied_once got=%b pulses_in_apply=%0d required=0/0", cfg_applied, pulses); end
        bus_read(6'd1, 32'd1);
        bus_read(6'd0, 32'd1);
        drain();
        wait_locked();
        @(negedge clk);
        pll_rst = 1'b1;
        #1;
        total++;
        if (locked !== 1'b0) begin bad++; $display("FAIL pll_rst_comb_unlock got=%b required=0", locked); end
        repeat (8) @(negedge clk);
        pll_rst = 1'b0;
        check_lock_after(64, "pll_rst");
    endtask

    task automatic test_write_during_apply;
        bus_write(6'd2, 32'd0);
        bus_write(6'd5, 32'h12345);
        total++;
        if (c0_cfg !== 32'h20302) begin bad++; $display("FAIL c0_not_applied got=%h required=20302", c0_cfg); end
        bus_read(6'd5, 32'h12345);
        drain();
        bus_write(6'd2, 32'd0);
        @(negedge clk);
        wait_ready("apply2");
        total++;
        if (c0_cfg !== 32'h12345) begin bad++; $display("FAIL c0_second_apply got=%h required=12345", c0_cfg); end
        wait_locked();
    endtask

    task automatic test_simultaneous;
        @(negedge clk);
        mgmt_write = 1'b1;
        mgmt_read = 1'b1;
        mgmt_address = 6'd5;
        mgmt_writedata = 32'h0000ABCD;
        wait_ready("wr_rd");
        @(posedge clk);
        #1;
        mgmt_write = 1'b0;
        mgmt_read = 1'b0;
        total++;
        if (mgmt_readdatavalid !== 1'b0) begin bad++; $display("FAIL dropped_read_rdv got=%b required=0", mgmt_readdatavalid); end
        bus_read(6'd5, 32'h0000ABCD);
        bus_read(6'd6, 32'd0);
        bus_write(6'd6, 32'hFFFFFFFF);
        bus_read(6'd6, 32'd0);
        bus_read(6'd2, 32'd0);
        bus_write(6'd8, 32'hFFFFFFF5);
        bus_read(6'd8, 32'd5);
        drain();
    endtask

    task automatic test_reset_mid_apply;
        bus_write(6'd7, 32'h66666666);
        bus_write(6'd2, 32'd0);
        repeat (3) @(negedge clk);
        total++;
        if (mgmt_waitrequest !== 1'b1) begin bad++; $display("FAIL mid_apply_stall got=%b required=1", mgmt_waitrequest); end
        rst_n = 1'b0;
        #1;
        total += 3;
        if (k_cfg !== 32'hB33332DD) begin bad++; $display("FAIL rst_mid_k got=%h required=b33332dd", k_cfg); end
        if (mgmt_waitrequest !== 1'b0) begin bad++; $display("FAIL rst_mid_waitrequest got=%b required=0", mgmt_waitrequest); end
        if (locked !== 1'b0) begin bad++; $display("FAIL rst_mid_locked got=%b required=0", locked); end
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(6'd7, 32'hB33332DD);
        drain();
    endtask

    initial begin
        test_reset();
        test_pending_write();
        test_full_sequence();
        test_write_during_apply();
        test_simultaneous();
        test_reset_mid_apply();
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL missing_reads got=%0d_outstanding required=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_mgmt_responder.md
Name: pll_mgmt_responder

Overview:
- Avalon-MM management-port responder: the slave side of the PLL reconfiguration write sequence issued from the CLK_50M domain.
- Holds pending and active M/N/K/C0/bandwidth/charge-pump registers. On an "apply" write it stalls the bus, commits the pending values, and models PLL relock through a `locked` output.
- Used as the synthesizable shadow-register and simulation model behind the frequency-stepping memory tester. The memtest bench uses it as the PLL-side responder.

Parameters:
- M_INIT, 'h00808, reset value of pending and active M
- N_INIT, 'h10000, reset value of pending and active N
- K_INIT, 'hB33332DD, reset value of pending and active K
- C_INIT, 'h20302, reset value of pending and active C0
- APPLY_CYCLES, 16, cycles waitrequest stays high after an apply write (min 1)
- LOCK_CYCLES, 64, cycles from end of apply or pll_rst release until locked=1 (min 1)

Ports:
- clk, in, 1, management clock
- rst_n, in, 1, asynchronous active-low reset
- mgmt_address, in, 6, register address
- mgmt_write, in, 1, write request
- mgmt_writedata, in, 32, write data
- mgmt_read, in, 1, read request
- mgmt_readdata, out, 32, read data
- mgmt_readdatavalid, out, 1, one-cycle read strobe
- mgmt_waitrequest, out, 1, stall
- pll_rst, in, 1, PLL reset request, active high
- locked, out, 1, modelled PLL lock
- m_cfg, n_cfg, k_cfg, c0_cfg, out, 32 each, active dividers
- bw_cfg, cp_cfg, out, 4 each, active bandwidth and charge pump (writedata[3:0])
- cfg_applied, out, 1, one-cycle pulse when active registers update

Behaviour:
- Reset (async, rst_n=0):
  - pending and active M/N/K/C0 = *_INIT; bw=7; cp=1; mode=0.
  - waitrequest=0, readdatavalid=0, readdata=0, cfg_applied=0, locked=0.
  - State=RELOCK with counter=LOCK_CYCLES.
- A request is accepted when (write|read) && !waitrequest.
- If write and read are both high, the write is accepted and the read is dropped: no readdatavalid.
- Register map (write targets pending copy; read returns pending copy):
  - 0 mode
  - 1 status, read-only: {30'b0, locked, busy}
  - 2 apply, write-only; reads 0
  - 3 N, 4 M, 5 C0, 7 K
  - 8 bandwidth, 9 charge pump: reads zero-extended [3:0]
  - Any other address: writes ignored, reads return 0.
- Read latency is 1: mgmt_readdata and mgmt_readdatavalid=1 in the cycle after acceptance. readdata holds its value otherwise.
- States:
  - IDLE: waitrequest=0.
    - Accepted write to address 2 -> APPLY, count=APPLY_CYCLES; waitrequest=1 and locked=0 from the next cycle.
  - APPLY: waitrequest=1, locked=0, count decrements each cycle.
    - At count==1: pending copied to active, cfg_applied pulses for 1 cycle, -> RELOCK with count=LOCK_CYCLES.
  - RELOCK: waitrequest=0 (register writes allowed), locked=0, count decrements.
    - At count==1 -> IDLE and locked=1.
    - Apply write accepted in RELOCK -> APPLY, count reloaded.
  - busy=1 in APPLY and RELOCK.
- pll_rst=1, any state:
  - locked=0 combinationally in the same cycle.
  - APPLY is not aborted.
  - In IDLE/RELOCK: state -> RELOCK and the counter is held at LOCK_CYCLES while pll_rst=1; counting starts on release.
  - In APPLY: on completion, RELOCK holds its counter while pll_rst=1.
- Active registers change only on APPLY completion. Back-to-back writes to the same register before apply: last value wins.
- rst_n asserted mid-APPLY: everything returns to reset values, and any pending values not yet applied are lost.
- Counters are 16-bit and never wrap. Zero-valued parameters are illegal; an elaboration assertion enforces this.

Test Plan:
- Reset release, no traffic -> locked=0 for 64 cycles, then locked=1; m_cfg='h00808, k_cfg='hB33332DD.
- Write M='h00707 (addr 4), read addr 4 -> readdatavalid one cycle later, data 'h00707; m_cfg still 'h00808 until apply.
- Full sequence 0,4,7,3,5,9,8,2 writing 160 MHz values, then pll_rst pulse of 8 cycles:
  - waitrequest high exactly 16 cycles after the apply.
  - cfg_applied pulses once; m_cfg='h00808, k_cfg=1, c0_cfg='h20302.
  - locked rises 64 cycles after pll_rst falls.
- Write issued during APPLY -> held by waitrequest, accepted the cycle waitrequest drops, and lands in pending only.
- Simultaneous write+read to addr 5 -> write takes effect, no readdatavalid. Read of addr 6 -> 0. Write to addr 6 -> ignored.
- rst_n low mid-APPLY after a K write of 'h66666666 -> k_cfg='hB33332DD, waitrequest=0 and locked=0 immediately.
